// File: rtl/rv_bus_arbiter.sv
// rv_bus_arbiter
//   Shares one slave memory port between NUM_MASTERS bus masters
//   (0 = core ibus, 1 = core dbus, 2 = debug system-bus master).
//   A registered arbiter picks one owner. The owner keeps the slave until
//   one of three things happens: the slave completes, the owner drops its
//   request, or the wait counter expires. When the counter expires, the
//   owner gets an error completion so that a hung slave cannot stall the
//   core forever.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   m_bstart[NM]        per-master request, held until that master's m_bdone
//   m_ttype[NM]         per-master direction (0 read, 1 write)
//   m_tsize[3*NM]       per-master size (load/store funct3 encoding)
//   m_addr/m_wdata      per-master 32-bit address / write data, packed by index
//   m_bdone/m_berr[NM]  completion pulse / timeout flag to the owning master
//   m_rdata             slave read data on a real completion, zero on timeout
//   s_*                 slave-side request, mirrored from the owner while granted
//   s_bdone, s_rdata    slave completion pulse and read data
//   busy, grant_idx     arbiter owns the slave / index of the owner

module rv_bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter bit RR_EN       = 1'b1,
    parameter int TIMEOUT_CYC = 255,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_MASTERS-1:0]    m_bstart,
    input  logic [NUM_MASTERS-1:0]    m_ttype,
    input  logic [3*NUM_MASTERS-1:0]  m_tsize,
    input  logic [32*NUM_MASTERS-1:0] m_addr,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]    m_bdone,
    output logic [NUM_MASTERS-1:0]    m_berr,
    output logic [31:0]               m_rdata,
    output logic                      s_bstart,
    output logic                      s_ttype,
    output logic [2:0]                s_tsize,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic                      s_bdone,
    input  logic [31:0]               s_rdata,
    output logic                      busy,
    output logic [GW-1:0]             grant_idx
);

    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_idx_q, grant_idx_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;

    logic [GW-1:0] win_idx;
    logic          win_vld;
    logic [GW-1:0] sel;
    logic          own_req;
    logic          in_grant;
    logic          done_evt;
    logic          abort_evt;
    logic          to_evt;

    // Winner selection. In round-robin mode, the search runs upward from
    // the pointer and then wraps: indices at or above the pointer are
    // tried first, then the ones below it.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        if (RR_EN) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!win_vld && m_bstart[k] && (GW'(k) >= rr_ptr_q)) begin
                    win_idx = GW'(k);
                    win_vld = 1'b1;
                end
            end
            for (int k = 0; k < NUM_MASTERS; k++) begin
                if (!win_vld && m_bstart[k] && (GW'(k) < rr_ptr_q)) begin
                    win_idx = GW'(k);
                    win_vld = 1'b1;
                end
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                if (!win_vld && m_bstart[k]) begin
                    win_idx = GW'(k);
                    win_vld = 1'b1;
                end
            end
        end
    end

    // Slave-side mux. Outside GRANT the mux selects master 0.
    always_comb begin
        in_grant = (state_q == ST_GRANT);
        sel      = in_grant ? grant_idx_q : '0;
        own_req  = 1'b0;
        s_ttype  = m_ttype[0];
        s_tsize  = m_tsize[2:0];
        s_addr   = m_addr[31:0];
        s_wdata  = m_wdata[31:0];
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (GW'(k) == sel) begin
                own_req = m_bstart[k];
                s_ttype = m_ttype[k];
                s_tsize = m_tsize[3*k +: 3];
                s_addr  = m_addr[32*k +: 32];
                s_wdata = m_wdata[32*k +: 32];
            end
        end
    end

    // Exit events. A slave completion beats both an abort and a timeout
    // in the same cycle.
    always_comb begin
        done_evt  = in_grant && s_bdone;
        abort_evt = in_grant && !s_bdone && !own_req;
        to_evt    = TO_EN && in_grant && !s_bdone && own_req && (cnt_q == CNT_MAX);
        s_bstart  = in_grant && own_req && !to_evt;
        m_rdata   = done_evt ? s_rdata : 32'h0;
        m_bdone   = '0;
        m_berr    = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (GW'(k) == grant_idx_q) begin
                m_bdone[k] = done_evt || to_evt;
                m_berr[k]  = to_evt;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d     = ST_GRANT;
                    busy_d      = 1'b1;
                    grant_idx_d = win_idx;
                    cnt_d       = '0;
                    if (RR_EN) begin
                        rr_ptr_d = (win_idx == GW'(NUM_MASTERS - 1)) ? '0 : win_idx + GW'(1);
                    end
                end
            end
            ST_GRANT: begin
                if (done_evt || abort_evt || to_evt) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q != '1) begin
                    // Saturating increment. With the timeout disabled, the
                    // counter parks at all-ones instead of wrapping.
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_rv_bus_arbiter.sv
module tb_rv_bus_arbiter;

    localparam int NM = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: round robin. Instance 1: fixed priority.
    logic        rst_n  [2];
    logic [2:0]  bstart [2];
    logic [2:0]  ttype  [2];
    logic [8:0]  tsize  [2];
    logic [95:0] addr   [2];
    logic [95:0] wdata  [2];
    logic        sbd    [2];
    logic [31:0] srd    [2];

    logic [2:0]  d_bdone [2];
    logic [2:0]  d_berr  [2];
    logic [31:0] d_rdata [2];
    logic        d_sb    [2];
    logic        d_tt    [2];
    logic [2:0]  d_ts    [2];
    logic [31:0] d_sa    [2];
    logic [31:0] d_sw    [2];
    logic        d_busy  [2];
    logic [1:0]  d_gi    [2];

    rv_bus_arbiter #(.NUM_MASTERS(NM), .RR_EN(1'b1), .TIMEOUT_CYC(TO)) u_rr (
        .clk(clk), .rst_n(rst_n[0]),
        .m_bstart(bstart[0]), .m_ttype(ttype[0]), .m_tsize(tsize[0]),
        .m_addr(addr[0]), .m_wdata(wdata[0]),
        .m_bdone(d_bdone[0]), .m_berr(d_berr[0]), .m_rdata(d_rdata[0]),
        .s_bstart(d_sb[0]), .s_ttype(d_tt[0]), .s_tsize(d_ts[0]),
        .s_addr(d_sa[0]), .s_wdata(d_sw[0]),
        .s_bdone(sbd[0]), .s_rdata(srd[0]),
        .busy(d_busy[0]), .grant_idx(d_gi[0])
    );

    rv_bus_arbiter #(.NUM_MASTERS(NM), .RR_EN(1'b0), .TIMEOUT_CYC(TO)) u_fp (
        .clk(clk), .rst_n(rst_n[1]),
        .m_bstart(bstart[1]), .m_ttype(ttype[1]), .m_tsize(tsize[1]),
        .m_addr(addr[1]), .m_wdata(wdata[1]),
        .m_bdone(d_bdone[1]), .m_berr(d_berr[1]), .m_rdata(d_rdata[1]),
        .s_bstart(d_sb[1]), .s_ttype(d_tt[1]), .s_tsize(d_ts[1]),
        .s_addr(d_sa[1]), .s_wdata(d_sw[1]),
        .s_bdone(sbd[1]), .s_rdata(srd[1]),
        .busy(d_busy[1]), .grant_idx(d_gi[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Behavioural model: owner is -1 when nobody holds the slave.
    int own [2] = '{-1, -1};
    int cnt [2] = '{0, 0};
    int ptr [2] = '{0, 0};
    int nw;
    logic [2:0] exp_done [2] = '{3'b000, 3'b000};

    function automatic int pick(input int i);
        if (i == 0) begin
            for (int k = 0; k < NM; k++)
                if (bstart[0][(ptr[0] + k) % NM]) return (ptr[0] + k) % NM;
        end else begin
            for (int k = NM - 1; k >= 0; k--)
                if (bstart[1][k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                own[i] = -1; cnt[i] = 0; ptr[i] = 0;
            end else if (own[i] < 0) begin
                nw = pick(i);
                if (nw >= 0) begin
                    own[i] = nw;
                    cnt[i] = 0;
                    if (i == 0) ptr[i] = (nw + 1) % NM;
                end
            end else if (sbd[i] || !bstart[i][own[i]] || cnt[i] >= TO) begin
                own[i] = -1;
            end else begin
                cnt[i]++;
            end
        end
    end

    logic       c_ge, c_req;
    logic [2:0] c_bd, c_be;
    logic       c_sb;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            c_ge = rst_n[i] && (own[i] >= 0);
            c_bd = 3'b000; c_be = 3'b000; c_sb = 1'b0;
            if (c_ge) begin
                c_req = bstart[i][own[i]];
                if (sbd[i]) c_bd[own[i]] = 1'b1;
                else if (c_req && cnt[i] >= TO) begin
                    c_bd[own[i]] = 1'b1;
                    c_be[own[i]] = 1'b1;
                end
                c_sb = c_req && (c_be == 3'b000);
            end
            exp_done[i] = c_bd;
            chk($sformatf("u%0d.busy", i), 32'(d_busy[i]), 32'(c_ge));
            chk($sformatf("u%0d.s_bstart", i), 32'(d_sb[i]), 32'(c_sb));
            chk($sformatf("u%0d.m_bdone", i), 32'(d_bdone[i]), 32'(c_bd));
            chk($sformatf("u%0d.m_berr", i), 32'(d_berr[i]), 32'(c_be));
            if (c_ge) begin
                chk($sformatf("u%0d.grant_idx", i), 32'(d_gi[i]), 32'(own[i]));
                chk($sformatf("u%0d.s_ttype", i), 32'(d_tt[i]), 32'(ttype[i][own[i]]));
                chk($sformatf("u%0d.s_tsize", i), 32'(d_ts[i]), 32'(tsize[i][3*own[i] +: 3]));
                chk($sformatf("u%0d.s_addr", i), d_sa[i], addr[i][32*own[i] +: 32]);
                chk($sformatf("u%0d.s_wdata", i), d_sw[i], wdata[i][32*own[i] +: 32]);
            end
            if (c_bd != 3'b000)
                chk($sformatf("u%0d.m_rdata", i), d_rdata[i], (c_be != 3'b000) ? 32'h0 : srd[i]);
        end
    end

    // Advance one cycle. Masters drop their request in the cycle after
    // their completion (expected completion taken from the model).
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < NM; k++)
                if (exp_done[i][k]) bstart[i][k] = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1; bstart[i] = '0; ttype[i] = '0; tsize[i] = '0;
            addr[i] = '0; wdata[i] = '0; sbd[i] = 1'b0; srd[i] = '0;
        end
        #2;
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.reset_busy", i), 32'(d_busy[i]), 32'd0);
            chk($sformatf("u%0d.reset_sb", i), 32'(d_sb[i]), 32'd0);
            chk($sformatf("u%0d.reset_gi", i), 32'(d_gi[i]), 32'd0);
            chk($sformatf("u%0d.reset_bdone", i), 32'(d_bdone[i]), 32'd0);
            chk($sformatf("u%0d.reset_berr", i), 32'(d_berr[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Round-robin contention with a zero-wait slave: grants 0,1,0,1.
        tick();
        bstart[0] = 3'b011; sbd[0] = 1'b1; srd[0] = 32'h1111_0000;
        settle();
        chk("rr.req_cycle_sb", 32'(d_sb[0]), 32'd0);
        for (int r = 0; r < 8; r++) begin
            tick();
            bstart[0] = (r < 7) ? 3'b011 : 3'b000;
            settle();
            if (r % 2 == 0) begin
                chk($sformatf("rr.round%0d_gi", r / 2), 32'(d_gi[0]), 32'((r / 2) % 2));
                chk($sformatf("rr.round%0d_bdone", r / 2), 32'(d_bdone[0]), 32'(3'b001 << ((r / 2) % 2)));
                chk($sformatf("rr.round%0d_rdata", r / 2), d_rdata[0], 32'h1111_0000);
            end else begin
                chk($sformatf("rr.gap%0d_busy", r / 2), 32'(d_busy[0]), 32'd0);
            end
        end
        tick(); sbd[0] = 1'b0;

        // ibus read of 0x100, two slave wait cycles.
        tick();
        bstart[0][0] = 1'b1; addr[0][31:0] = 32'h100; ttype[0][0] = 1'b0;
        tick(); settle();
        chk("rd.n1_sb", 32'(d_sb[0]), 32'd1);
        chk("rd.n1_addr", d_sa[0], 32'h100);
        chk("rd.n1_bdone", 32'(d_bdone[0]), 32'd0);
        tick(); settle();
        chk("rd.n2_bdone", 32'(d_bdone[0]), 32'd0);
        tick(); sbd[0] = 1'b1; srd[0] = 32'hCAFE_F00D; settle();
        chk("rd.n3_bdone", 32'(d_bdone[0]), 32'b001);
        chk("rd.n3_rdata", d_rdata[0], 32'hCAFE_F00D);
        chk("rd.n3_berr", 32'(d_berr[0]), 32'd0);
        tick(); sbd[0] = 1'b0; settle();
        chk("rd.n4_busy", 32'(d_busy[0]), 32'd0);

        // dbus write mirrored onto the slave side.
        tick();
        addr[0][31:0] = 32'hDEAD_0000; addr[0][63:32] = 32'h2000;
        wdata[0][63:32] = 32'h1234_5678; tsize[0][5:3] = 3'b010;
        ttype[0][1] = 1'b1; bstart[0][1] = 1'b1;
        tick(); settle();
        chk("wr.gi", 32'(d_gi[0]), 32'd1);
        chk("wr.ttype", 32'(d_tt[0]), 32'd1);
        chk("wr.tsize", 32'(d_ts[0]), 32'd2);
        chk("wr.addr", d_sa[0], 32'h2000);
        chk("wr.wdata", d_sw[0], 32'h1234_5678);
        tick(); sbd[0] = 1'b1; settle();
        chk("wr.bdone", 32'(d_bdone[0]), 32'b010);
        tick(); sbd[0] = 1'b0; settle();
        chk("wr.bdone_once", 32'(d_bdone[0]), 32'd0);

        // Slave never answers: timeout at grant+8.
        tick(); addr[0][31:0] = 32'h300; bstart[0][0] = 1'b1;
        tick(); settle();
        chk("to.grant_busy", 32'(d_busy[0]), 32'd1);
        repeat (7) tick();
        settle();
        chk("to.g7_bdone", 32'(d_bdone[0]), 32'd0);
        chk("to.g7_sb", 32'(d_sb[0]), 32'd1);
        tick(); settle();
        chk("to.g8_bdone", 32'(d_bdone[0]), 32'b001);
        chk("to.g8_berr", 32'(d_berr[0]), 32'b001);
        chk("to.g8_rdata", d_rdata[0], 32'h0);
        chk("to.g8_sb", 32'(d_sb[0]), 32'd0);
        tick(); settle();
        chk("to.g9_busy", 32'(d_busy[0]), 32'd0);

        // Slave completion coinciding with the timeout wins.
        tick(); bstart[0][0] = 1'b1;
        tick();
        repeat (7) tick();
        tick(); sbd[0] = 1'b1; srd[0] = 32'h55AA_1234; settle();
        chk("tc.bdone", 32'(d_bdone[0]), 32'b001);
        chk("tc.berr", 32'(d_berr[0]), 32'd0);
        chk("tc.rdata", d_rdata[0], 32'h55AA_1234);
        tick(); sbd[0] = 1'b0;

        // Debug aborts mid-transaction; ibus is served next.
        tick(); addr[0][95:64] = 32'h4000; bstart[0][2] = 1'b1;
        tick(); bstart[0][0] = 1'b1; settle();
        chk("ab.gi_debug", 32'(d_gi[0]), 32'd2);
        tick(); bstart[0][2] = 1'b0; settle();
        chk("ab.sb_low", 32'(d_sb[0]), 32'd0);
        chk("ab.no_bdone", 32'(d_bdone[0]), 32'd0);
        tick(); settle();
        chk("ab.idle", 32'(d_busy[0]), 32'd0);
        tick(); settle();
        chk("ab.next_gi", 32'(d_gi[0]), 32'd0);
        chk("ab.next_busy", 32'(d_busy[0]), 32'd1);
        tick(); sbd[0] = 1'b1; settle();
        chk("ab.next_bdone", 32'(d_bdone[0]), 32'b001);
        tick(); sbd[0] = 1'b0;

        // Reset during GRANT, then check that the pointer is back at 0.
        tick(); bstart[0][0] = 1'b1;
        tick(); settle();
        chk("rs.busy_before", 32'(d_busy[0]), 32'd1);
        rst_n[0] = 1'b0; bstart[0] = 3'b000;
        #1;
        chk("rs.busy_async", 32'(d_busy[0]), 32'd0);
        chk("rs.sb_async", 32'(d_sb[0]), 32'd0);
        chk("rs.gi_async", 32'(d_gi[0]), 32'd0);
        tick(); tick();
        rst_n[0] = 1'b1;
        tick(); bstart[0] = 3'b011;
        tick(); sbd[0] = 1'b1; settle();
        chk("rs.ptr0_gi", 32'(d_gi[0]), 32'd0);
        chk("rs.ptr0_bdone", 32'(d_bdone[0]), 32'b001);
        tick(); tick(); settle();
        chk("rs.then_dbus", 32'(d_gi[0]), 32'd1);
        tick(); bstart[0] = 3'b000; sbd[0] = 1'b0;

        // Fixed priority: debug first, then dbus beats ibus.
        tick(); bstart[1] = 3'b111; sbd[1] = 1'b1; srd[1] = 32'h77;
        tick(); settle();
        chk("fp.gi_debug", 32'(d_gi[1]), 32'd2);
        chk("fp.bdone_debug", 32'(d_bdone[1]), 32'b100);
        tick(); settle();
        chk("fp.gap1", 32'(d_busy[1]), 32'd0);
        tick(); settle();
        chk("fp.gi_dbus", 32'(d_gi[1]), 32'd1);
        tick(); settle();
        chk("fp.gap2", 32'(d_busy[1]), 32'd0);
        tick(); settle();
        chk("fp.gi_ibus", 32'(d_gi[1]), 32'd0);
        tick(); bstart[1] = 3'b000; sbd[1] = 1'b0;

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
